// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states
// and the op-code width.
package md_pkg;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } md_state_e;

endpackage

// File: rtl/md_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not borrow.
module md_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};

  // The partial remainder stays below the divisor, so the MSB of diff is a clean borrow flag.
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Operands are reduced to
// magnitudes at issue, iterated WIDTH times, and sign-corrected in FIX.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc, div_acc;
  logic [WIDTH-1:0]   div_rem;
  logic               div_q;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
  assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  md_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .divisor_i (opnd_q),
    .bit_i     (acc_q[WIDTH-1]),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );
  assign div_acc = {div_rem, acc_q[WIDTH-2:0], div_q};

  assign prod_s = neg_q     ? -acc_q                  : acc_q;
  assign quo_s  = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
  assign rem_s  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // NOTE: every next-state signal takes its held value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            unique case (op)
              MD_MULT, MD_MULTU: begin
                state_d   = ST_RUN;
                cnt_d     = '0;
                is_div_d  = 1'b0;
                acc_d     = {{WIDTH{1'b0}}, b_mag};
                opnd_d    = a_mag;
                neg_d     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                rem_neg_d = 1'b0;
              end
              MD_DIV, MD_DIVU: begin
                state_d   = ST_RUN;
                cnt_d     = '0;
                is_div_d  = 1'b1;
                acc_d     = {{WIDTH{1'b0}}, a_mag};
                opnd_d    = b_mag;
                neg_d     = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                rem_neg_d = signed_op & a[WIDTH-1];
              end
              MD_MTHI: hi_d = a;
              MD_MTLO: lo_d = a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          acc_d = is_div_q ? div_acc : mul_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d = ST_IDLE;
          if (is_div_q) begin
            // A zero divisor leaves remainder = |a| (re-signed to a); quotient is forced to all ones.
            lo_d = (opnd_q == '0) ? '1 : quo_s;
            hi_d = rem_s;
          end else begin
            {hi_d, lo_d} = prod_s;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  // NOTE: iteration registers are reset along with HI/LO so a reset leaves no stale operand state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit (WIDTH = 32): expected {hi,lo} pushed at issue,
// popped and compared when busy falls or the MTHI/MTLO write lands.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [63:0] sb[$];
  logic [31:0] m_hi, m_lo;

  md_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sp;
    logic signed [31:0] sx, sy;
    logic [63:0] r;
    sx = x;
    sy = y;
    r  = '0;
    case (o)
      MD_MULT: begin
        sp = 64'(sx) * 64'(sy);
        r  = sp;
      end
      MD_MULTU: r = {32'h0, x} * {32'h0, y};
      MD_DIV: begin
        if (y == 32'h0)                                r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == '1)        r = {32'h0, 32'h8000_0000};
        else                                           r = {32'(sx % sy), 32'(sx / sy)};
      end
      MD_DIVU: begin
        if (y == 32'h0) r = {x, 32'hFFFF_FFFF};
        else            r = {x % y, x / y};
      end
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  function automatic logic [63:0] pop_exp();
    logic [63:0] e;
    if (sb.size() == 0) begin
      e = {m_hi, m_lo};
      $display("FAIL scoreboard_empty: got empty queue expected an entry");
      errors++;
    end else begin
      e = sb.pop_front();
    end
    return e;
  endfunction

  // Caller is at a negedge; issue at the next posedge and wait for completion.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input bit poke, input string tag);
    int n;
    logic [63:0] e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    sb.push_back(exp);
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin
      n++;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      if (n == 5) begin
        check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
        if (poke) begin
          start = 1'b1;
          op    = MD_DIVU;
          $display("WARN protocol: start asserted while busy (%s)", tag);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'd33);
    e = pop_exp();
    check({tag, "_hilo"}, {hi, lo}, e);
    {m_hi, m_lo} = e;
  endtask

  task automatic mt_op(input logic [2:0] o, input logic [31:0] x, input string tag);
    logic [63:0] e;
    start = 1'b1;
    op    = o;
    a     = x;
    sb.push_back((o == MD_MTHI) ? {x, m_lo} : {m_hi, x});
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd0);
    e = pop_exp();
    check({tag, "_hilo"}, {hi, lo}, e);
    {m_hi, m_lo} = e;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;

    reset_n = 1'b1;
    start   = 1'b0;
    flush   = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    m_hi    = '0;
    m_lo    = '0;
    #2 reset_n = 1'b0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed cases, issued back-to-back on the first idle cycle.
    run_op(MD_MULT,  32'hFFFF_FFFF, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFE}, 1'b0, "mult_neg1x2");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h2, {32'h0000_0001, 32'hFFFF_FFFE}, 1'b0, "multu_x2");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b1, "multu_max");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "div_m7_2");
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, "div_min_m1");
    run_op(MD_DIVU,  32'h7, 32'h0, {32'h7, 32'hFFFF_FFFF}, 1'b0, "divu_by0");
    mt_op(MD_MTLO, 32'h1234_5678, "mtlo");
    mt_op(MD_MTHI, 32'hCAFE_F00D, "mthi");
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0, "div_by0");
    run_op(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 1'b1, "div_7_m2");

    // Random operations checked against a native-arithmetic model.
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = $urandom;
      if (i == 2) ry = 32'h0;
      if (i == 5) ry = 32'($urandom_range(1, 255));
      run_op(ro, rx, ry, model(ro, rx, ry), bit'(i % 2), "rand");
    end

    // Reserved op codes do nothing.
    for (int i = 6; i < 8; i++) begin
      start = 1'b1;
      op    = 3'(i);
      a     = $urandom;
      @(negedge clk);
      start = 1'b0;
      check("reserved_busy", 64'(busy), 64'd0);
      check("reserved_hilo", {hi, lo}, {m_hi, m_lo});
    end

    // Flush after ten RUN edges: busy drops, HI/LO untouched, no late write.
    start = 1'b1;
    op    = MD_MULT;
    a     = 32'h0000_1234;
    b     = 32'hFFFF_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    repeat (40) @(negedge clk);
    check("flush_late_hilo", {hi, lo}, {m_hi, m_lo});

    // Start together with flush in IDLE is discarded.
    start = 1'b1;
    flush = 1'b1;
    op    = MD_MULTU;
    a     = 32'h5;
    b     = 32'h6;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("start_flush_hilo", {hi, lo}, {m_hi, m_lo});

    // Asynchronous reset in the middle of a DIVU.
    start = 1'b1;
    op    = MD_DIVU;
    a     = 32'h0012_3456;
    b     = 32'h0000_0033;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    check("rst_late_busy", 64'(busy), 64'd0);
    check("rst_late_hilo", {hi, lo}, 64'h0);

    run_op(MD_MULTU, 32'h3, 32'h5, {32'h0, 32'hF}, 1'b0, "post_reset_mult");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised iterative multiply/divide unit for the MIPS pipeline, sitting in the EX stage beside the ALU and owning the HI/LO register pair. It runs MULT/MULTU/DIV/DIVU as a shift-add or restoring-divide sequence over WIDTH+1 cycles. While it runs it raises `busy`, so hazard control can stall dependent MFHI/MFLO and new MD operations. It also accepts MTHI/MTLO writes and supports flushing an in-flight operation on an exception or interrupt.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 4 and even.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue the operation in `op` this cycle.
- `op`  in  3  operation code from `md_pkg`.
- `a`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  WIDTH  rt operand: multiplier or divisor.
- `flush`  in  1  abort the in-flight operation; HI/LO are not written.
- `busy`  out  1  an operation is in progress.
- `hi`  out  WIDTH  HI register: product upper half or remainder.
- `lo`  out  WIDTH  LO register: product lower half or quotient.

## Operation
- Op codes: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5. Codes 6 and 7 are reserved; `start` with a reserved code is a no-op.
- FSM states:
  - IDLE → RUN: on `start` with op 0–3, `!busy` and `!flush`.
  - RUN → FIX: after WIDTH iterations.
  - FIX → IDLE: writes `hi`/`lo`.
  - Any state → IDLE: on `flush`.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at issue.
  - Result sign is applied in FIX.
  - Product sign = sign(a) ^ sign(b).
  - Quotient sign = sign(a) ^ sign(b).
  - Remainder sign = sign(a), i.e. truncating division.
- Multiply: WIDTH shift-add steps into a 2·WIDTH accumulator. Result is {hi,lo} = full 2·WIDTH product.
- Divide: WIDTH restoring steps. Result is lo = quotient, hi = remainder.
- Divide by zero (signed or unsigned): hi = a, lo = all ones. Latency is the same as a normal divide.
- Signed MIN / −1: lo = MIN, hi = 0. This falls out of the magnitude datapath naturally; no special case.
- MTHI/MTLO:
  - Accepted only when `!busy`.
  - Writes `hi` or `lo` from `a` at that edge.
  - The other register is unchanged.
  - `busy` stays low.
- `start` while `busy`:
  - Ignored; the in-flight operation continues unchanged.
  - Hazard control must stall instead. The bench flags this as a protocol warning, not an error.
- `flush`:
  - Takes priority over `start` and over completion in the same cycle.
  - The FSM returns to IDLE and `busy` falls at the next edge.
  - `hi`/`lo` are not written. A `start` in the same cycle is discarded.
- Operand and sign latches are captured at issue. Changes on `a`/`b` during RUN have no effect.

## Timing
- Reset (asynchronous, while `reset_n` = 0):
  - `busy` = 0, `hi` = 0, `lo` = 0, state = IDLE.
  - All iteration registers = 0.
- Release is synchronous to `clk`. The first issue can occur on the first edge with `reset_n` = 1.
- Multiply/divide latency: issue at edge k.
  - `busy` = 1 from after edge k through the cycle before edge k+WIDTH+1.
  - `hi`/`lo` update and `busy` falls at edge k+WIDTH+1.
  - For WIDTH = 32, `busy` is high for exactly 33 cycles.
- Back-to-back: a new `start` is accepted at edge k+WIDTH+1's successor cycle, i.e. the first cycle `busy` reads 0.
- MTHI/MTLO: zero latency; the value is visible on `hi`/`lo` in the cycle after the issuing edge.
- `hi`/`lo` are registers. They change only at completion, on MTHI/MTLO, or on reset.
- Reset mid-operation: immediate return to the reset values; no partial write.

## Structure
- `md_pkg`: op-code constants, FSM state enum, and the `MD_OP_W` = 3 constant.
- Sub-module `md_divstep`:
  - One restoring-divide step; combinational, WIDTH-parametrised.
  - Inputs: partial remainder, divisor, next dividend bit.
  - Outputs: new remainder and quotient bit.
  - Instantiated once and reused every RUN cycle.
- Top level holds the FSM, iteration counter (clog2(WIDTH+1) bits), magnitude/sign latches, accumulator, and the HI/LO registers.

## Test plan
All scenarios use WIDTH = 32; each op is issued at edge k.
- MULT a=0xFFFFFFFF, b=0x00000002 → at k+33: hi=0xFFFFFFFF, lo=0xFFFFFFFE; `busy` high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0x00000002 → hi=0x00000001, lo=0xFFFFFFFE. Then MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7, b=0 → hi=0x00000007, lo=0xFFFFFFFF at k+33. Then MTLO a=0x12345678 → lo=0x12345678 next cycle, hi unchanged.
- MULT issued, `flush` asserted at k+10 → `busy` 0 after edge k+10; hi/lo keep their prior values. A `start` asserted during RUN is ignored; the result matches the original operands.
- `reset_n` pulsed low at k+20 of a DIVU → `busy`, hi, lo read 0 asynchronously; no later write occurs.
